// File: rtl/cmp_tally.sv
// Tallies a window of magnitude-comparator flag samples and reports the
// strict-majority outcome with a one-cycle DONE pulse.
module cmp_tally #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic             LT,
  input  logic             GT,
  input  logic             EQ,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] LT_CNT,
  output logic [CNT_W-1:0] GT_CNT,
  output logic [CNT_W-1:0] EQ_CNT,
  output logic [1:0]       RESULT,
  output logic             ERR
);

  generate
    if (WINDOW < 1 || CNT_W < $clog2(WINDOW + 1)) begin : g_bad_params
      $error("cmp_tally: WINDOW must be >= 1 and CNT_W >= clog2(WINDOW+1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    REPORT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_t           state;
  logic [CNT_W-1:0] sample_cnt;
  logic [CNT_W-1:0] lt_nxt;
  logic [CNT_W-1:0] gt_nxt;
  logic [CNT_W-1:0] eq_nxt;
  logic             one_hot;

  // A tie for the maximum (including all-zero counters) reports "none".
  function automatic logic [1:0] majority(input logic [CNT_W-1:0] l,
                                          input logic [CNT_W-1:0] g,
                                          input logic [CNT_W-1:0] e);
    if (l > g && l > e) return 2'b01;
    if (g > l && g > e) return 2'b10;
    if (e > l && e > g) return 2'b11;
    return 2'b00;
  endfunction

  always_comb begin
    one_hot = $onehot({LT, GT, EQ});
    lt_nxt  = LT_CNT;
    gt_nxt  = GT_CNT;
    eq_nxt  = EQ_CNT;
    if (IN_VALID && one_hot) begin
      if (LT) lt_nxt = LT_CNT + ONE;
      if (GT) gt_nxt = GT_CNT + ONE;
      if (EQ) eq_nxt = EQ_CNT + ONE;
    end
  end

  // RESULT is loaded on entry to REPORT so it is already valid alongside DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      RESULT     <= 2'b00;
      LT_CNT     <= '0;
      GT_CNT     <= '0;
      EQ_CNT     <= '0;
      sample_cnt <= '0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            state      <= COLLECT;
            BUSY       <= 1'b1;
            ERR        <= 1'b0;
            RESULT     <= 2'b00;
            LT_CNT     <= '0;
            GT_CNT     <= '0;
            EQ_CNT     <= '0;
            sample_cnt <= '0;
          end
        end
        COLLECT: begin
          if (IN_VALID) begin
            LT_CNT     <= lt_nxt;
            GT_CNT     <= gt_nxt;
            EQ_CNT     <= eq_nxt;
            sample_cnt <= sample_cnt + ONE;
            if (!one_hot) ERR <= 1'b1;
            if (sample_cnt == LAST) begin
              state  <= REPORT;
              BUSY   <= 1'b0;
              DONE   <= 1'b1;
              RESULT <= majority(lt_nxt, gt_nxt, eq_nxt);
            end
          end
        end
        REPORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_tally.sv
// Directed bench for cmp_tally: a queue-based window model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_cmp_tally;

  localparam int WINDOW = 4;
  localparam int CNT_W  = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             inValid;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] ltCnt;
  logic [CNT_W-1:0] gtCnt;
  logic [CNT_W-1:0] eqCnt;
  logic [1:0]       result;
  logic             err;

  int totalChecks = 0;
  int badChecks   = 0;
  int busyCycles  = 0;
  int donePulses  = 0;

  cmp_tally #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
    .CLK(clock), .RST(reset), .START(start), .IN_VALID(inValid),
    .LT(lt), .GT(gt), .EQ(eq),
    .BUSY(busy), .DONE(done), .LT_CNT(ltCnt), .GT_CNT(gtCnt),
    .EQ_CNT(eqCnt), .RESULT(result), .ERR(err)
  );

  always #5 clock = ~clock;

  // Reference model: samples of the open window kept as {lt,gt,eq} triples.
  logic [2:0] window[$];
  bit         modelReady = 0;
  bit         mCollect   = 0;
  bit         mDone      = 0;
  bit         mErr       = 0;
  int         mLt = 0, mGt = 0, mEq = 0;
  int         mResult    = 0;

  task automatic recount();
    mLt = 0; mGt = 0; mEq = 0; mErr = 0;
    foreach (window[i]) begin
      case (window[i])
        3'b100:  mLt++;
        3'b010:  mGt++;
        3'b001:  mEq++;
        default: mErr = 1;
      endcase
    end
  endtask

  task automatic pickWinner();
    int best;
    int holders;
    int code;
    best = mLt;
    if (mGt > best) best = mGt;
    if (mEq > best) best = mEq;
    holders = 0;
    code = 0;
    if (mLt == best) begin holders++; code = 1; end
    if (mGt == best) begin holders++; code = 2; end
    if (mEq == best) begin holders++; code = 3; end
    mResult = (best == 0 || holders > 1) ? 0 : code;
  endtask

  always @(posedge clock) begin
    if (reset) begin
      window.delete();
      mCollect = 0; mDone = 0; mErr = 0; mResult = 0;
      mLt = 0; mGt = 0; mEq = 0;
      modelReady = 1;
    end else if (mDone) begin
      mDone = 0;
    end else if (!mCollect) begin
      if (start) begin
        window.delete();
        recount();
        mResult = 0;
        mCollect = 1;
      end
    end else if (inValid) begin
      window.push_back({lt, gt, eq});
      recount();
      if (window.size() == WINDOW) begin
        pickWinner();
        mCollect = 0;
        mDone = 1;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    totalChecks++;
    if (actual != expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (modelReady) begin
      checkOutput("model.busy",   int'(busy),   int'(mCollect));
      checkOutput("model.done",   int'(done),   int'(mDone));
      checkOutput("model.err",    int'(err),    int'(mErr));
      checkOutput("model.result", int'(result), mResult);
      checkOutput("model.ltCnt",  int'(ltCnt),  mLt);
      checkOutput("model.gtCnt",  int'(gtCnt),  mGt);
      checkOutput("model.eqCnt",  int'(eqCnt),  mEq);
      if (busy) busyCycles++;
      if (done) donePulses++;
    end
  end

  task automatic applyStimulus(input bit r, input bit s, input bit v, input logic [2:0] f);
    reset = r; start = s; inValid = v; {lt, gt, eq} = f;
    @(negedge clock);
  endtask

  task automatic sample(input logic [2:0] f);
    applyStimulus(0, 0, 1, f);
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 3'b000);
  endtask

  task automatic begin_window();
    busyCycles = 0;
    donePulses = 0;
    applyStimulus(0, 1, 0, 3'b000);
  endtask

  initial begin
    // Reset held with START and IN_VALID active must still win.
    applyStimulus(1, 1, 1, 3'b100);
    applyStimulus(1, 1, 1, 3'b100);
    checkOutput("reset.busy",   int'(busy),   0);
    checkOutput("reset.done",   int'(done),   0);
    checkOutput("reset.err",    int'(err),    0);
    checkOutput("reset.result", int'(result), 0);
    checkOutput("reset.counts", int'(ltCnt) + int'(gtCnt) + int'(eqCnt), 0);
    idle();

    // Majority GT, contiguous samples.
    begin_window();
    sample(3'b010); sample(3'b010); sample(3'b100); sample(3'b010);
    checkOutput("gt.doneLatency", int'(done), 1);
    checkOutput("gt.resultWithDone", int'(result), 2);
    idle(); idle();
    checkOutput("gt.ltCnt", int'(ltCnt), 1);
    checkOutput("gt.gtCnt", int'(gtCnt), 3);
    checkOutput("gt.eqCnt", int'(eqCnt), 0);
    checkOutput("gt.result", int'(result), 2);
    checkOutput("gt.busyCycles", busyCycles, 4);
    checkOutput("gt.donePulses", donePulses, 1);

    // Gaps between valid samples.
    begin_window();
    sample(3'b001); idle(); sample(3'b001); idle(); idle(); sample(3'b100);
    checkOutput("gap.noEarlyDone", int'(done), 0);
    sample(3'b001);
    checkOutput("gap.done", int'(done), 1);
    idle(); idle();
    checkOutput("gap.eqCnt", int'(eqCnt), 3);
    checkOutput("gap.ltCnt", int'(ltCnt), 1);
    checkOutput("gap.result", int'(result), 3);
    checkOutput("gap.donePulses", donePulses, 1);

    // Tie between LT and GT.
    begin_window();
    sample(3'b100); sample(3'b100); sample(3'b010); sample(3'b010);
    idle(); idle();
    checkOutput("tie.ltCnt", int'(ltCnt), 2);
    checkOutput("tie.gtCnt", int'(gtCnt), 2);
    checkOutput("tie.result", int'(result), 0);
    checkOutput("tie.donePulses", donePulses, 1);

    // Non-one-hot sample still consumes a window slot.
    begin_window();
    sample(3'b001); sample(3'b110); sample(3'b001); sample(3'b001);
    idle(); idle();
    checkOutput("bad.err", int'(err), 1);
    checkOutput("bad.eqCnt", int'(eqCnt), 3);
    checkOutput("bad.ltgt", int'(ltCnt) + int'(gtCnt), 0);
    checkOutput("bad.result", int'(result), 3);
    begin_window();
    checkOutput("bad.errCleared", int'(err), 0);
    checkOutput("bad.countsCleared", int'(eqCnt), 0);
    applyStimulus(1, 0, 0, 3'b000);
    idle();

    // All-zero flag samples: no counts, error set, no winner.
    begin_window();
    sample(3'b000); sample(3'b000); sample(3'b111); sample(3'b000);
    idle(); idle();
    checkOutput("zero.err", int'(err), 1);
    checkOutput("zero.result", int'(result), 0);
    checkOutput("zero.counts", int'(ltCnt) + int'(gtCnt) + int'(eqCnt), 0);

    // START during COLLECT is ignored; reset aborts without DONE.
    begin_window();
    sample(3'b100); sample(3'b100);
    applyStimulus(0, 1, 0, 3'b000);
    checkOutput("abort.stillBusy", int'(busy), 1);
    checkOutput("abort.ltKept", int'(ltCnt), 2);
    applyStimulus(1, 0, 1, 3'b100);
    checkOutput("abort.busy", int'(busy), 0);
    checkOutput("abort.ltCnt", int'(ltCnt), 0);
    sample(3'b100); sample(3'b100); idle(); idle();
    checkOutput("abort.donePulses", donePulses, 0);
    checkOutput("abort.idleIgnoresSamples", int'(ltCnt), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/cmp_tally.md
Name: cmp_tally

Overview:
- Downstream consumer of the 4-bit magnitude comparator's A_lt_B / A_gt_B / A_eq_B flags.
- On START, collects a window of WINDOW valid comparison results and tallies each outcome.
- Reports the majority outcome with a one-cycle DONE pulse.
- Flags any sample whose flags are not exactly one-hot.

Parameters:
- WINDOW, 8, number of valid samples per tally window (>= 1).
- CNT_W, 4, width of each tally counter. Must satisfy CNT_W >= clog2(WINDOW+1). Violation is an elaboration error.

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  synchronous reset, active-high.
- START  input  1  begin a new window; honoured only in IDLE.
- IN_VALID  input  1  LT/GT/EQ carry a comparison result this cycle.
- LT  input  1  comparator A_lt_B.
- GT  input  1  comparator A_gt_B.
- EQ  input  1  comparator A_eq_B.
- BUSY  output  1  high while in COLLECT.
- DONE  output  1  one-cycle pulse when the tally is complete.
- LT_CNT  output  CNT_W  count of LT samples in the window.
- GT_CNT  output  CNT_W  count of GT samples in the window.
- EQ_CNT  output  CNT_W  count of EQ samples in the window.
- RESULT  output  2  majority outcome: 00 none/tie, 01 LT, 10 GT, 11 EQ.
- ERR  output  1  sticky: a non-one-hot sample occurred in the current window.

Behaviour:
- Reset: state IDLE; BUSY, DONE, ERR, RESULT, all counters and the internal sample count are 0.
  - Reset wins over every other input in the same cycle.
  - Reset during COLLECT aborts the window; no DONE is produced.
- All outputs are registered.
- FSM states: IDLE, COLLECT, REPORT.
- IDLE:
  - START=1 clears LT_CNT, GT_CNT, EQ_CNT, RESULT, ERR and the sample count, then moves to COLLECT.
  - Samples presented in the START cycle are ignored.
  - Counters and RESULT from the previous window hold until the next START.
- COLLECT:
  - BUSY=1. START is ignored.
  - Each cycle with IN_VALID=1 consumes one sample and increments the sample count.
  - If exactly one of LT/GT/EQ is high, the matching counter increments.
  - Otherwise (zero or multiple flags high) no counter increments, ERR is set, and the sample still counts toward WINDOW.
  - IN_VALID=0 cycles are ignored; gaps are allowed.
  - The cycle that accepts the WINDOW-th valid sample transitions to REPORT.
- REPORT (exactly one cycle):
  - DONE=1 and BUSY=0. RESULT is updated this same cycle, computed from the final counters.
  - RESULT = the counter that is strictly greatest. If two or more counters share the maximum, or all are 0, RESULT=00.
  - START is ignored. Next state is IDLE.
- Latency: DONE asserts on the clock edge after the WINDOW-th valid sample is accepted.
- Counters never wrap, guaranteed by the CNT_W rule. LT_CNT+GT_CNT+EQ_CNT <= WINDOW, with equality iff ERR=0.

Test Plan (WINDOW=4, CNT_W=4):
- Reset: hold RST=1 for 2 cycles with START=1 and IN_VALID=1 -> BUSY=0, DONE=0, ERR=0, RESULT=00, all counters 0.
- Majority GT: START, then contiguous GT,GT,LT,GT -> DONE pulses for 1 cycle the cycle after the 4th sample; GT_CNT=3, LT_CNT=1, EQ_CNT=0, RESULT=10, ERR=0; BUSY=1 for exactly 4 cycles.
- Gaps: START, then EQ, idle, EQ, idle, idle, LT, EQ -> DONE only after the 4th valid sample; EQ_CNT=3, LT_CNT=1, RESULT=11.
- Tie: START, then LT,LT,GT,GT -> LT_CNT=2, GT_CNT=2, RESULT=00, DONE pulses once.
- Illegal flags: START, then EQ, (LT+GT both high), EQ, EQ -> ERR=1, EQ_CNT=3, LT_CNT=0, GT_CNT=0, RESULT=11. The next START clears ERR to 0.
- Abort/ignore: START, 2 valid LT samples, then pulse START again -> window unaffected. Then RST=1 for 1 cycle -> state IDLE, counters 0, no DONE ever emitted for that window.
